// File: rtl/instr_decode_pipe.sv
// Pipelined instruction decoder with valid/ready handshakes and a per-register busy scoreboard.
// Optional stall counter output is built when DECODE_STALL_CNT_EN is defined.
module instr_decode_pipe #(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 5,
  parameter int REG_W   = 3,
  parameter int IMM_W   = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OPC_W-1:0]      aluopcode,
  output logic [REG_W-1:0]      writereg,
  output logic [REG_W-1:0]      readreg1,
  output logic [REG_W-1:0]      readreg2,
  output logic [IMM_W-1:0]      imme,
  output logic                  regen,
  output logic                  use_rs2,
  input  logic                  wb_valid,
  input  logic [REG_W-1:0]      wb_reg,
  output logic [2**REG_W-1:0]   busy
`ifdef DECODE_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int NREGS = 2**REG_W;

  logic [OPC_W-1:0] opc_s;
  logic [REG_W-1:0] rd_s;
  logic [REG_W-1:0] rs1_s;
  logic [REG_W-1:0] rs2_s;
  logic [IMM_W-1:0] imm_s;
  logic             regen_s;
  logic             use_rs2_s;
  logic [NREGS-1:0] clr_mask_s;
  logic [NREGS-1:0] set_mask_s;
  logic [NREGS-1:0] busy_eff_s;
  logic             hazard_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             retire_s;

  logic             out_valid_r;
  logic [OPC_W-1:0] opc_r;
  logic [REG_W-1:0] rd_r;
  logic [REG_W-1:0] rs1_r;
  logic [REG_W-1:0] rs2_r;
  logic [IMM_W-1:0] imm_r;
  logic             regen_r;
  logic             use_rs2_r;
  logic [NREGS-1:0] busy_r;

  assign opc_s = instr[INSTR_W-1 -: OPC_W];
  assign rd_s  = instr[INSTR_W-OPC_W-1 -: REG_W];
  assign rs1_s = instr[INSTR_W-OPC_W-REG_W-1 -: REG_W];
  assign rs2_s = instr[INSTR_W-OPC_W-2*REG_W-1 -: REG_W];
  assign imm_s = instr[IMM_W-1:0];

  // Decode classes, hazard check against the bypassed scoreboard, and handshake qualifiers.
  always_comb begin
    regen_s   = (opc_s != {OPC_W{1'b1}});
    use_rs2_s = ~opc_s[OPC_W-1];
    if (wb_valid) begin
      clr_mask_s = {{(NREGS-1){1'b0}}, 1'b1} << wb_reg;
    end else begin
      clr_mask_s = {NREGS{1'b0}};
    end
    // A writeback landing this cycle already frees its register for the hazard check.
    busy_eff_s = busy_r & ~clr_mask_s;
    hazard_s   = busy_eff_s[rs1_s] | (use_rs2_s & busy_eff_s[rs2_s]) | (regen_s & busy_eff_s[rd_s]);
    in_ready_s = enable & ~reset & ~hazard_s & (~out_valid_r | out_ready);
    accept_s   = in_valid & in_ready_s;
    retire_s   = out_valid_r & out_ready & enable;
    if (accept_s & regen_s) begin
      set_mask_s = {{(NREGS-1){1'b0}}, 1'b1} << rd_s;
    end else begin
      set_mask_s = {NREGS{1'b0}};
    end
  end

  // Output bundle registers and busy scoreboard; set beats clear on the same register.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      opc_r       <= {OPC_W{1'b0}};
      rd_r        <= {REG_W{1'b0}};
      rs1_r       <= {REG_W{1'b0}};
      rs2_r       <= {REG_W{1'b0}};
      imm_r       <= {IMM_W{1'b0}};
      regen_r     <= 1'b0;
      use_rs2_r   <= 1'b0;
      busy_r      <= {NREGS{1'b0}};
    end else begin
      busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
      if (accept_s) begin
        out_valid_r <= 1'b1;
        opc_r       <= opc_s;
        rd_r        <= rd_s;
        rs1_r       <= rs1_s;
        rs2_r       <= rs2_s;
        imm_r       <= imm_s;
        regen_r     <= regen_s;
        use_rs2_r   <= use_rs2_s;
      end else if (retire_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

`ifdef DECODE_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles an offered instruction is held back by a hazard.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_r <= 16'h0000;
    end else if (in_valid & enable & hazard_s & (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign aluopcode = opc_r;
  assign writereg  = rd_r;
  assign readreg1  = rs1_r;
  assign readreg2  = rs2_r;
  assign imme      = imm_r;
  assign regen     = regen_r;
  assign use_rs2   = use_rs2_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Self-checking bench for instr_decode_pipe: directed scenarios plus randomized traffic
// compared against a field-arithmetic reference model of decode, handshake and scoreboard.
module tb_instr_decode_pipe;

  localparam int NR = 8;

  logic        clock = 1'b0;
  logic        reset, enable, in_valid, out_ready, wb_valid;
  logic [15:0] instr;
  logic [2:0]  wb_reg;
  logic        in_ready, out_valid, regen, use_rs2;
  logic [4:0]  aluopcode;
  logic [2:0]  writereg, readreg1, readreg2;
  logic [8:0]  imme;
  logic [7:0]  busy;
`ifdef DECODE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_busy[NR];
  bit m_ov;
  int m_opc, m_rd, m_rs1, m_rs2, m_imm, m_stall;
  bit m_regen, m_use2;

  instr_decode_pipe dut (
    .clock(clock), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluopcode(aluopcode), .writereg(writereg), .readreg1(readreg1), .readreg2(readreg2),
    .imme(imme), .regen(regen), .use_rs2(use_rs2),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .busy(busy)
`ifdef DECODE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit m_hazard();
    int w = int'(instr);
    int opc = w / 2048;
    int rd = (w / 256) % 8;
    int rs1 = (w / 32) % 8;
    int rs2 = (w / 4) % 8;
    bit eff[NR];
    for (int i = 0; i < NR; i++) eff[i] = m_busy[i] && !(wb_valid && int'(wb_reg) == i);
    return eff[rs1] || ((opc < 16) && eff[rs2]) || ((opc != 31) && eff[rd]);
  endfunction

  function automatic bit m_ready();
    return enable && !reset && !m_hazard() && (!m_ov || out_ready);
  endfunction

  function automatic logic [7:0] m_busy_vec();
    logic [7:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic drive(input bit r, input bit en, input bit iv, input logic [15:0] ins,
                       input bit ordy, input bit wbv, input logic [2:0] wbr);
    reset = r; enable = en; in_valid = iv; instr = ins;
    out_ready = ordy; wb_valid = wbv; wb_reg = wbr;
    #1;
  endtask

  // Update the model with the current inputs, then move past the next rising edge.
  task automatic advance();
    int w = int'(instr);
    int rd = (w / 256) % 8;
    bit hz = m_hazard();
    bit acc = in_valid && m_ready();
    bit ret = m_ov && out_ready && enable;
    bit rg = (w / 2048) != 31;
    if (reset) begin
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      m_ov = 0; m_opc = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0;
      m_regen = 0; m_use2 = 0; m_stall = 0;
    end else begin
      if (in_valid && enable && hz && m_stall < 65535) m_stall++;
      for (int i = 0; i < NR; i++) begin
        if (wb_valid && int'(wb_reg) == i) m_busy[i] = 1'b0;
        if (acc && rg && rd == i) m_busy[i] = 1'b1;
      end
      if (acc) begin
        m_ov = 1; m_opc = w / 2048; m_rd = rd; m_rs1 = (w / 32) % 8;
        m_rs2 = (w / 4) % 8; m_imm = w % 512; m_regen = rg; m_use2 = (w / 2048) < 16;
      end else if (ret) begin
        m_ov = 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 16'hFFFF, 1, 0, 3'd0); advance();
    drive(1, 1, 0, 16'h0000, 1, 0, 3'd0); advance();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 8'h00) begin n_fail++; $display("FAIL reset_busy: got %h want 00", busy); end
    n_checks++;
    if ({aluopcode, writereg, readreg1, readreg2, imme, regen, use_rs2} !== 25'd0) begin
      n_fail++; $display("FAIL reset_fields: op=%h rd=%h rs1=%h rs2=%h imm=%h regen=%b use_rs2=%b want all 0",
                         aluopcode, writereg, readreg1, readreg2, imme, regen, use_rs2);
    end
  endtask

  task automatic test_basic_decode();
    drive(0, 1, 1, 16'b0101011110001011, 1, 0, 3'd0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
    advance();
    drive(0, 1, 0, 16'h0000, 1, 0, 3'd0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
    n_checks++;
    if (aluopcode !== 5'b01010 || writereg !== 3'd7 || readreg1 !== 3'd4 || readreg2 !== 3'd2) begin
      n_fail++; $display("FAIL basic_regs: op=%b rd=%0d rs1=%0d rs2=%0d want 01010 7 4 2", aluopcode, writereg, readreg1, readreg2);
    end
    n_checks++; if (imme !== 9'h18B) begin n_fail++; $display("FAIL basic_imm: got %h want 18b", imme); end
    n_checks++; if (regen !== 1'b1 || use_rs2 !== 1'b1) begin n_fail++; $display("FAIL basic_class: regen=%b use_rs2=%b want 1 1", regen, use_rs2); end
    n_checks++; if (busy !== 8'h80) begin n_fail++; $display("FAIL basic_busy: got %h want 80", busy); end
    advance();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_retire: got %b want 0", out_valid); end
  endtask

  task automatic test_immediate();
    drive(1, 1, 0, 16'h0000, 1, 0, 3'd0); advance();
    drive(0, 1, 1, 16'b1010001110101101, 1, 0, 3'd0); advance();
    n_checks++;
    if (aluopcode !== 5'b10100 || writereg !== 3'd3 || readreg1 !== 3'd5 || imme !== 9'h1AD) begin
      n_fail++; $display("FAIL imm_fields: op=%b rd=%0d rs1=%0d imm=%h want 10100 3 5 1ad", aluopcode, writereg, readreg1, imme);
    end
    n_checks++; if (use_rs2 !== 1'b0 || regen !== 1'b1) begin n_fail++; $display("FAIL imm_class: use_rs2=%b regen=%b want 0 1", use_rs2, regen); end
    n_checks++; if (busy !== 8'h08) begin n_fail++; $display("FAIL imm_busy: got %h want 08", busy); end
  endtask

  task automatic test_raw_stall();
    drive(1, 1, 0, 16'h0000, 1, 0, 3'd0); advance();
    drive(0, 1, 1, 16'b0101011110001011, 1, 0, 3'd0); advance();
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 1, 16'h09E0, 1, 0, 3'd0);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_ready c%0d: got %b want 0", c, in_ready); end
      advance();
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_drained: got %b want 0", out_valid); end
    drive(0, 1, 1, 16'h09E0, 1, 1, 3'd7);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_bypass_ready: got %b want 1", in_ready); end
    advance();
    n_checks++;
    if (out_valid !== 1'b1 || aluopcode !== 5'b00001 || readreg1 !== 3'd7) begin
      n_fail++; $display("FAIL raw_accept: ov=%b op=%b rs1=%0d want 1 00001 7", out_valid, aluopcode, readreg1);
    end
    n_checks++; if (busy !== 8'h02) begin n_fail++; $display("FAIL raw_busy: got %h want 02", busy); end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 5; c++) begin
      drive(0, 1, 1, 16'h1400, 0, 0, 3'd0);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready c%0d: got %b want 0", c, in_ready); end
      advance();
      n_checks++;
      if (out_valid !== 1'b1 || aluopcode !== 5'b00001 || readreg1 !== 3'd7 || writereg !== 3'd1) begin
        n_fail++; $display("FAIL bp_hold c%0d: ov=%b op=%b rs1=%0d rd=%0d want 1 00001 7 1", c, out_valid, aluopcode, readreg1, writereg);
      end
    end
    drive(0, 1, 1, 16'h1400, 1, 0, 3'd0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    advance();
    n_checks++;
    if (out_valid !== 1'b1 || aluopcode !== 5'b00010 || writereg !== 3'd4) begin
      n_fail++; $display("FAIL bp_b2b: ov=%b op=%b rd=%0d want 1 00010 4", out_valid, aluopcode, writereg);
    end
    n_checks++; if (busy !== 8'h12) begin n_fail++; $display("FAIL bp_busy: got %h want 12", busy); end
  endtask

  task automatic test_collision_nop();
    drive(1, 1, 0, 16'h0000, 1, 0, 3'd0); advance();
    drive(0, 1, 1, 16'h1A00, 1, 0, 3'd0); advance();
    drive(0, 1, 1, 16'h1A00, 1, 1, 3'd2);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL coll_ready: got %b want 1", in_ready); end
    advance();
    n_checks++; if (busy !== 8'h04) begin n_fail++; $display("FAIL coll_busy: got %h want 04", busy); end
    drive(0, 1, 1, 16'hFD00, 1, 0, 3'd0); advance();
    n_checks++;
    if (out_valid !== 1'b1 || aluopcode !== 5'b11111 || regen !== 1'b0 || use_rs2 !== 1'b0) begin
      n_fail++; $display("FAIL nop_class: ov=%b op=%b regen=%b use_rs2=%b want 1 11111 0 0", out_valid, aluopcode, regen, use_rs2);
    end
    n_checks++; if (busy !== 8'h04) begin n_fail++; $display("FAIL nop_busy: got %h want 04", busy); end
  endtask

  task automatic test_reset_enable();
    drive(1, 1, 0, 16'h0000, 1, 0, 3'd0); advance();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 1, 16'(32768 + i * 256 + i * 32), 1, 0, 3'd0); advance();
    end
    n_checks++; if (busy !== 8'hFF || out_valid !== 1'b1) begin n_fail++; $display("FAIL fill: busy=%h ov=%b want ff 1", busy, out_valid); end
    drive(1, 1, 1, 16'h0000, 1, 1, 3'd0);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", in_ready); end
    advance();
    n_checks++;
    if (busy !== 8'h00 || out_valid !== 1'b0 || {aluopcode, writereg, readreg1, readreg2, imme, regen, use_rs2} !== 25'd0) begin
      n_fail++; $display("FAIL midrst: busy=%h ov=%b op=%h imm=%h want 00 0 0 0", busy, out_valid, aluopcode, imme);
    end
    drive(0, 1, 1, 16'h0B00, 1, 0, 3'd0); advance();
    drive(0, 0, 1, 16'h1400, 1, 1, 3'd3);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL en0_ready: got %b want 0", in_ready); end
    advance();
    n_checks++; if (busy !== 8'h00) begin n_fail++; $display("FAIL en0_wb_clear: got %h want 00", busy); end
    n_checks++;
    if (out_valid !== 1'b1 || aluopcode !== 5'b00001 || writereg !== 3'd3) begin
      n_fail++; $display("FAIL en0_hold: ov=%b op=%b rd=%0d want 1 00001 3", out_valid, aluopcode, writereg);
    end
  endtask

`ifdef DECODE_STALL_CNT_EN
  task automatic test_stall_cnt();
    drive(1, 1, 0, 16'h0000, 1, 0, 3'd0); advance();
    drive(0, 1, 1, 16'b0101011110001011, 1, 0, 3'd0); advance();
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 1, 16'h09E0, 1, 0, 3'd0); advance();
    end
    n_checks++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt); end
  endtask
`endif

  task automatic test_random();
    logic [15:0] w;
    drive(1, 1, 0, 16'h0000, 1, 0, 3'd0); advance();
    for (int c = 0; c < 600; c++) begin
      w = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 9) == 0) w[15:11] = 5'b11111;
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 70, w,
            $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 35, 3'($urandom_range(0, 7)));
      n_checks++; if (in_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, m_ready()); end
      advance();
      n_checks++; if (out_valid !== m_ov) begin n_fail++; $display("FAIL rnd_out_valid c%0d: got %b want %b", c, out_valid, m_ov); end
      n_checks++; if (busy !== m_busy_vec()) begin n_fail++; $display("FAIL rnd_busy c%0d: got %h want %h", c, busy, m_busy_vec()); end
      n_checks++;
      if (aluopcode !== 5'(m_opc) || writereg !== 3'(m_rd) || readreg1 !== 3'(m_rs1) || readreg2 !== 3'(m_rs2)
          || imme !== 9'(m_imm) || regen !== m_regen || use_rs2 !== m_use2) begin
        n_fail++; $display("FAIL rnd_fields c%0d: got %h/%0d/%0d/%0d/%h/%b/%b want %h/%0d/%0d/%0d/%h/%b/%b", c,
                           aluopcode, writereg, readreg1, readreg2, imme, regen, use_rs2,
                           m_opc, m_rd, m_rs1, m_rs2, m_imm, m_regen, m_use2);
      end
`ifdef DECODE_STALL_CNT_EN
      n_checks++; if (stall_cnt !== 16'(m_stall)) begin n_fail++; $display("FAIL rnd_stall c%0d: got %0d want %0d", c, stall_cnt, m_stall); end
`endif
    end
  endtask

  initial begin
    drive(1, 0, 0, 16'h0000, 0, 0, 3'd0);
    test_reset();
    test_basic_decode();
    test_immediate();
    test_raw_stall();
    test_backpressure();
    test_collision_nop();
    test_reset_enable();
`ifdef DECODE_STALL_CNT_EN
    test_stall_cnt();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_decode_pipe.md
Name: instr_decode_pipe

Overview:
Parametrised, pipelined successor to the single-stage instruction decoder. Splits each instruction into opcode, destination, two sources and an immediate, using a fixed field layout sized by parameters. Adds valid/ready handshakes on both sides and a per-register busy scoreboard that stalls issue on RAW/WAW hazards until writeback clears them. Sits between instruction fetch and the register file / ALU issue stage.

Parameters:
INSTR_W, 16, instruction width; must satisfy INSTR_W >= OPC_W + 3*REG_W.
OPC_W, 5, opcode width.
REG_W, 3, register index width; NREGS = 2**REG_W (default 8).
IMM_W, 9, immediate width; taken from instr[IMM_W-1:0].

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
enable  in  1  global advance qualifier; 0 = stage frozen
in_valid  in  1  instruction present
in_ready  out  1  stage accepts instruction this cycle
instr  in  INSTR_W  instruction word
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts bundle
aluopcode  out  OPC_W  instr[INSTR_W-1 -: OPC_W]
writereg  out  REG_W  next REG_W bits below opcode (default [10:8])
readreg1  out  REG_W  next REG_W bits (default [7:5])
readreg2  out  REG_W  next REG_W bits (default [4:2])
imme  out  IMM_W  instr[IMM_W-1:0] (default [8:0]; may overlap register fields)
regen  out  1  bundle writes writereg
use_rs2  out  1  bundle reads readreg2
wb_valid  in  1  writeback of a register completes
wb_reg  in  REG_W  register being written back
busy  out  NREGS  scoreboard, bit i = register i has a write in flight

Behaviour:
- Clock is clock; reset is synchronous and active-high.
- Reset: out_valid=0; aluopcode, writereg, readreg1, readreg2, imme, regen, use_rs2 = 0; busy = 0. Reset wins over every other event in the same cycle.
- Decode classes, evaluated on the input instruction:
  - regen = (opcode != all-ones). All-ones is the NOP/store class.
  - use_rs2 = (opcode MSB == 0). MSB=1 is the immediate form.
- Effective busy: busy_eff = busy & ~(wb_valid ? onehot(wb_reg) : 0). Writeback clears bypass the hazard check in the same cycle.
- hazard = busy_eff[rs1] | (use_rs2 & busy_eff[rs2]) | (regen & busy_eff[rd]).
- in_ready = enable & ~reset & ~hazard & (~out_valid | out_ready). This is combinational and does not depend on in_valid.
- Accept when in_valid & in_ready:
  - Output registers load the decoded fields at the next edge; out_valid=1 next cycle. Latency is 1 cycle.
  - If regen, busy[rd] is set.
- Output handshake:
  - Bundle retires when out_valid & out_ready & enable.
  - A simultaneous accept replaces it, giving back-to-back throughput of 1/cycle.
  - Retire with no accept clears out_valid.
  - Output fields hold while out_valid & ~out_ready.
- Scoreboard update each cycle: next busy = (busy & ~clear_mask) | set_mask.
  - Set and clear of the same register in one cycle: set wins, so the register stays busy.
  - wb_valid for a non-busy register: no effect.
  - wb_valid is honoured even when enable=0.
- enable=0: no accept, no retire, outputs and out_valid hold.
- Reset mid-operation: the in-flight bundle is dropped and the scoreboard is cleared. Writebacks for pre-reset instructions arriving later are harmless, since clearing a non-busy register has no effect.

Optional Feature:
- Macro: DECODE_STALL_CNT_EN.
- Defined: adds output port stall_cnt (16 bits). It increments each cycle where in_valid & enable & hazard, saturates at 0xFFFF, and resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic decode. After reset, enable=1, out_ready=1, instr=16'b0101011110001011 with in_valid=1 for one cycle. Next cycle: out_valid=1, aluopcode=5'b01010, writereg=7, readreg1=4, readreg2=2, imme=9'h18B, regen=1, use_rs2=1, busy=8'h80.
- Immediate form. instr=16'b1010001110101101 with busy=0. Expect aluopcode=5'b10100, writereg=3, readreg1=5, imme=9'h1AD, use_rs2=0, busy[3] set.
- RAW stall. Issue a write to r7, then present an instruction with rs1=7. in_ready=0 until wb_valid=1, wb_reg=7. In that wb cycle in_ready=1 (bypass) and the instruction is accepted the same cycle.
- Backpressure. Hold out_ready=0 with a bundle valid: in_ready=0 and outputs stable over 5 cycles. Raise out_ready with in_valid high: retire and accept in one cycle, out_valid stays 1.
- Set/clear collision plus NOP. Accept a write to r2 while wb_valid=1, wb_reg=2: busy[2] remains 1. Opcode 5'b11111 gives regen=0 and leaves busy unchanged.
- Reset and enable. Assert reset with busy=8'hFF and out_valid=1: next cycle everything is 0. With enable=0 and in_valid=1: no accept, but a wb_valid clear still takes effect. With DECODE_STALL_CNT_EN defined: a 3-cycle hazard stall gives stall_cnt=3.
